// File: rtl/trace_pkg.sv
// trace_pkg: shared record, kind and state types for the retire trace unit.
package trace_pkg;

  // Records carry counter fields at this fixed width. Narrower CYC_W
  // configurations zero-extend into it, and the constant upper bits fall away.
  localparam int TRACE_CNT_MAX_W = 64;

  typedef enum logic [2:0] {
    KIND_NOP  = 3'd0,
    KIND_REG  = 3'd1,
    KIND_LD   = 3'd2,
    KIND_ST   = 3'd3,
    KIND_HALT = 3'd4
  } trace_kind_e;

  typedef struct packed {
    trace_kind_e                kind;
    logic [TRACE_CNT_MAX_W-1:0] inum;
    logic [TRACE_CNT_MAX_W-1:0] cycle;
    logic [15:0]                pc;
    logic [3:0]                 regNum;
    logic [15:0]                value;
    logic [15:0]                addr;
  } trace_rec_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_DONE   = 2'd2
  } trace_state_e;

  // First match wins: halt beats load, load beats plain register write, etc.
  function automatic trace_kind_e classifyKind(input logic halt, input logic regWrite,
                                               input logic memRead, input logic memWrite);
    if (halt) return KIND_HALT;
    if (regWrite && memRead) return KIND_LD;
    if (regWrite) return KIND_REG;
    if (memWrite) return KIND_ST;
    return KIND_NOP;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: circular record buffer, up to NUM_PORTS pushes and one pop per cycle.
// The caller compacts records into pushRec[0 .. pushCount-1] and never pushes
// more than the free space seen at the start of the cycle.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int NUM_PORTS = 1,
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [CNT_W-1:0]            pushCount,
  input  trace_rec_t [NUM_PORTS-1:0]  pushRec,
  input  logic                        pop,
  output trace_rec_t                  headRec,
  output logic [CNT_W-1:0]            count
);

  trace_rec_t mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic popFire;

  assign popFire = pop && (count != '0);
  assign headRec = mem[rdPtr];

  // Storage: write the compacted records into consecutive slots from wrPtr.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (CNT_W'(k) < pushCount) mem[wrPtr + PTR_W'(k)] <= pushRec[k];
    end
  end

  // Pointers wrap naturally modulo DEPTH; occupancy tracks pushes minus pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      wrPtr <= wrPtr + pushCount[PTR_W-1:0];
      rdPtr <= rdPtr + PTR_W'(popFire);
      count <= count + pushCount - CNT_W'(popFire);
    end
  end

endmodule

// File: rtl/retire_trace_buffer.sv
// retire_trace_buffer: classifies retiring instructions into trace records,
// buffers them, and runs the halt-drain sequence and cycle watchdog.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_RUN     | accepting retires, watchdog armed
// ST_HALTED  | HALT seen (kept or dropped); retires ignored, FIFO draining
// ST_DONE    | drained after halt, or watchdog expired; left only by reset
module retire_trace_buffer
  import trace_pkg::*;
#(
  parameter int NUM_PORTS = 1,
  parameter int DEPTH = 16,
  parameter int CYC_W = 32,
  parameter int MAX_CYCLES = 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_PORTS-1:0]    ret_valid,
  input  logic [16*NUM_PORTS-1:0] ret_pc,
  input  logic [NUM_PORTS-1:0]    ret_regwrite,
  input  logic [NUM_PORTS-1:0]    ret_memread,
  input  logic [NUM_PORTS-1:0]    ret_memwrite,
  input  logic [NUM_PORTS-1:0]    ret_halt,
  input  logic [4*NUM_PORTS-1:0]  ret_wreg,
  input  logic [16*NUM_PORTS-1:0] ret_wdata,
  input  logic [16*NUM_PORTS-1:0] ret_addr,
  input  logic [16*NUM_PORTS-1:0] ret_mdata,
  output logic                    trace_valid,
  input  logic                    trace_ready,
  output logic [2:0]              trace_kind,
  output logic [CYC_W-1:0]        trace_inum,
  output logic [CYC_W-1:0]        trace_cycle,
  output logic [15:0]             trace_pc,
  output logic [15:0]             trace_value,
  output logic [15:0]             trace_addr,
  output logic [3:0]              trace_reg,
  output logic                    overflow,
  output logic [CYC_W-1:0]        drop_count,
  output logic                    timeout,
  output logic                    done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  trace_state_e state;
  logic [CYC_W-1:0] cycleCount;
  logic [CYC_W-1:0] cycleNext;
  logic [CYC_W-1:0] instCount;
  logic [CYC_W-1:0] wdCount;
  logic [CNT_W-1:0] fifoCount;
  logic [CNT_W-1:0] freeSlots;
  logic [CNT_W-1:0] pushCount;
  logic [CNT_W-1:0] numCounted;
  logic [CNT_W-1:0] numDropped;
  trace_rec_t [NUM_PORTS-1:0] pushRec;
  trace_rec_t slotRec;
  trace_rec_t headRec;
  trace_rec_t headOut;
  logic popFire;
  logic wdFire;
  logic accepting;
  logic haltTaken;
  logic unusedHeadBits;

  function automatic logic [CYC_W-1:0] satAdd(input logic [CYC_W-1:0] a, input logic [CYC_W-1:0] b);
    logic [CYC_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CYC_W] ? '1 : sum[CYC_W-1:0];
  endfunction

  assign cycleNext   = satAdd(cycleCount, CYC_W'(1));
  assign trace_valid = (fifoCount != '0);
  assign popFire     = trace_valid && trace_ready;
  // wdCount hits zero once cycleCount == MAX_CYCLES, so the firing edge is
  // the one that takes the cycle count past the limit.
  assign wdFire      = (state == ST_RUN) && (wdCount == '0);
  assign accepting   = (state == ST_RUN) && !wdFire;
  assign freeSlots   = CNT_W'(DEPTH) - fifoCount;

  // Classify each slot in age order, stop after the first HALT, and keep the
  // oldest records that fit the space free at the start of the cycle.
  always_comb begin
    pushRec    = '0;
    slotRec    = '0;
    pushCount  = '0;
    numCounted = '0;
    numDropped = '0;
    haltTaken  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      slotRec = '0;
      if (accepting && ret_valid[i] && !haltTaken) begin
        slotRec.kind  = classifyKind(ret_halt[i], ret_regwrite[i], ret_memread[i], ret_memwrite[i]);
        slotRec.inum  = TRACE_CNT_MAX_W'(satAdd(instCount, CYC_W'(numCounted)));
        slotRec.cycle = TRACE_CNT_MAX_W'(cycleNext);
        slotRec.pc    = ret_pc[16*i +: 16];
        case (slotRec.kind)
          KIND_LD: begin
            slotRec.regNum = ret_wreg[4*i +: 4];
            slotRec.value  = ret_wdata[16*i +: 16];
            slotRec.addr   = ret_addr[16*i +: 16];
          end
          KIND_REG: begin
            slotRec.regNum = ret_wreg[4*i +: 4];
            slotRec.value  = ret_wdata[16*i +: 16];
          end
          KIND_ST: begin
            slotRec.addr  = ret_addr[16*i +: 16];
            slotRec.value = ret_mdata[16*i +: 16];
          end
          default: ;
        endcase
        if (numCounted < freeSlots) begin
          for (int k = 0; k < NUM_PORTS; k++) begin
            if (CNT_W'(k) == pushCount) pushRec[k] = slotRec;
          end
          pushCount = pushCount + CNT_W'(1);
        end else begin
          numDropped = numDropped + CNT_W'(1);
        end
        numCounted = numCounted + CNT_W'(1);
        if (ret_halt[i]) haltTaken = 1'b1;
      end
    end
  end

  trace_fifo #(
    .NUM_PORTS(NUM_PORTS),
    .DEPTH(DEPTH)
  ) uFifo (
    .clk(clk),
    .rst_n(rst_n),
    .pushCount(pushCount),
    .pushRec(pushRec),
    .pop(popFire),
    .headRec(headRec),
    .count(fifoCount)
  );

  // Outputs read zero whenever no record is at the head.
  assign headOut     = trace_valid ? headRec : '0;
  assign trace_kind  = headOut.kind;
  assign trace_inum  = headOut.inum[CYC_W-1:0];
  assign trace_cycle = headOut.cycle[CYC_W-1:0];
  assign trace_pc    = headOut.pc;
  assign trace_value = headOut.value;
  assign trace_addr  = headOut.addr;
  assign trace_reg   = headOut.regNum;
  assign unusedHeadBits = ^{headOut.inum, headOut.cycle};

  // Counters, sticky flags, watchdog and the run/halt/done state machine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      cycleCount <= '0;
      instCount  <= '0;
      wdCount    <= CYC_W'(MAX_CYCLES);
      drop_count <= '0;
      overflow   <= 1'b0;
      timeout    <= 1'b0;
      done       <= 1'b0;
    end else begin
      cycleCount <= cycleNext;
      if (wdCount != '0) wdCount <= wdCount - CYC_W'(1);
      instCount  <= satAdd(instCount, CYC_W'(numCounted));
      drop_count <= satAdd(drop_count, CYC_W'(numDropped));
      if (numDropped != '0) overflow <= 1'b1;
      case (state)
        ST_RUN: begin
          if (wdFire) begin
            timeout <= 1'b1;
            done    <= 1'b1;
            state   <= ST_DONE;
          end else if (haltTaken) begin
            state <= ST_HALTED;
          end
        end
        ST_HALTED: begin
          // No pushes here, so the FIFO empties exactly when the last entry pops.
          if (fifoCount == CNT_W'(popFire)) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_retire_trace_buffer.sv
// tb_retire_trace_buffer: directed checks on a single-port instance (A) and a
// dual-port, depth-4, short-watchdog instance (B).
module tb_retire_trace_buffer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Instance A: NUM_PORTS=1, DEPTH=16
  logic aValid, aRegwrite, aMemread, aMemwrite, aHalt, aReady;
  logic [15:0] aPc, aWdata, aAddr, aMdata;
  logic [3:0] aWreg;
  logic aTValid, aOverflow, aTimeout, aDone;
  logic [2:0] aKind;
  logic [31:0] aInum, aCycle, aDrop;
  logic [15:0] aTPc, aValue, aTAddr;
  logic [3:0] aReg;

  // Instance B: NUM_PORTS=2, DEPTH=4, MAX_CYCLES=50
  logic [1:0] bValid, bRegwrite, bMemread, bMemwrite, bHalt;
  logic bReady;
  logic [31:0] bPc, bWdata, bAddr, bMdata;
  logic [7:0] bWreg;
  logic bTValid, bOverflow, bTimeout, bDone;
  logic [2:0] bKind;
  logic [31:0] bInum, bCycle, bDrop;
  logic [15:0] bTPc, bValue, bTAddr;
  logic [3:0] bReg;

  retire_trace_buffer #(.NUM_PORTS(1), .DEPTH(16), .CYC_W(32), .MAX_CYCLES(100000)) dutA (
    .clk(clk), .rst_n(rst_n),
    .ret_valid(aValid), .ret_pc(aPc), .ret_regwrite(aRegwrite), .ret_memread(aMemread),
    .ret_memwrite(aMemwrite), .ret_halt(aHalt), .ret_wreg(aWreg), .ret_wdata(aWdata),
    .ret_addr(aAddr), .ret_mdata(aMdata),
    .trace_valid(aTValid), .trace_ready(aReady), .trace_kind(aKind), .trace_inum(aInum),
    .trace_cycle(aCycle), .trace_pc(aTPc), .trace_value(aValue), .trace_addr(aTAddr),
    .trace_reg(aReg), .overflow(aOverflow), .drop_count(aDrop), .timeout(aTimeout), .done(aDone)
  );

  retire_trace_buffer #(.NUM_PORTS(2), .DEPTH(4), .CYC_W(32), .MAX_CYCLES(50)) dutB (
    .clk(clk), .rst_n(rst_n),
    .ret_valid(bValid), .ret_pc(bPc), .ret_regwrite(bRegwrite), .ret_memread(bMemread),
    .ret_memwrite(bMemwrite), .ret_halt(bHalt), .ret_wreg(bWreg), .ret_wdata(bWdata),
    .ret_addr(bAddr), .ret_mdata(bMdata),
    .trace_valid(bTValid), .trace_ready(bReady), .trace_kind(bKind), .trace_inum(bInum),
    .trace_cycle(bCycle), .trace_pc(bTPc), .trace_value(bValue), .trace_addr(bTAddr),
    .trace_reg(bReg), .overflow(bOverflow), .drop_count(bDrop), .timeout(bTimeout), .done(bDone)
  );

  task automatic clearInputs();
    aValid = 0; aRegwrite = 0; aMemread = 0; aMemwrite = 0; aHalt = 0; aReady = 0;
    aPc = 0; aWdata = 0; aAddr = 0; aMdata = 0; aWreg = 0;
    bValid = 0; bRegwrite = 0; bMemread = 0; bMemwrite = 0; bHalt = 0; bReady = 0;
    bPc = 0; bWdata = 0; bAddr = 0; bMdata = 0; bWreg = 0;
  endtask

  // Leaves rst_n released just after a falling edge; the next rising edge is edge 1.
  task automatic doReset();
    clearInputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    clearInputs();
    rst_n = 0;
    @(negedge clk);
    vectors++; if (aTValid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %0b want 0", aTValid); end
    vectors++; if (aKind !== 3'd0) begin miscompares++; $display("FAIL rst_kind got %0d want 0", aKind); end
    vectors++; if (aOverflow !== 1'b0 || aTimeout !== 1'b0 || aDone !== 1'b0) begin miscompares++; $display("FAIL rst_flags got ov=%0b to=%0b dn=%0b want 0", aOverflow, aTimeout, aDone); end
    vectors++; if (aDrop !== 32'd0) begin miscompares++; $display("FAIL rst_drop got %0d want 0", aDrop); end
    vectors++; if (bTValid !== 1'b0 || bDone !== 1'b0) begin miscompares++; $display("FAIL rst_b got v=%0b dn=%0b want 0", bTValid, bDone); end
    rst_n = 1;
  endtask

  task automatic test_reg_halt();
    doReset();
    aReady = 1;
    aValid = 1; aRegwrite = 1; aWreg = 4'd3; aWdata = 16'h00AB; aPc = 16'h0002;
    @(negedge clk);
    vectors++; if (aTValid !== 1'b1) begin miscompares++; $display("FAIL reg_valid got %0b want 1", aTValid); end
    vectors++; if (aKind !== 3'd1) begin miscompares++; $display("FAIL reg_kind got %0d want 1", aKind); end
    vectors++; if (aInum !== 32'd0) begin miscompares++; $display("FAIL reg_inum got %0d want 0", aInum); end
    vectors++; if (aReg !== 4'd3 || aValue !== 16'h00AB) begin miscompares++; $display("FAIL reg_fields got r%0d=%h want r3=00ab", aReg, aValue); end
    vectors++; if (aTPc !== 16'h0002 || aCycle !== 32'd1) begin miscompares++; $display("FAIL reg_pc_cycle got pc=%h cyc=%0d want 0002/1", aTPc, aCycle); end
    aRegwrite = 0; aWreg = 0; aWdata = 0; aHalt = 1; aPc = 16'h0004;
    @(negedge clk);
    vectors++; if (aKind !== 3'd4 || aInum !== 32'd1) begin miscompares++; $display("FAIL halt_rec got kind=%0d inum=%0d want 4/1", aKind, aInum); end
    vectors++; if (aTPc !== 16'h0004 || aValue !== 16'h0 || aReg !== 4'd0) begin miscompares++; $display("FAIL halt_fields got pc=%h v=%h r=%0d want 0004/0/0", aTPc, aValue, aReg); end
    vectors++; if (aCycle !== 32'd2 || aDone !== 1'b0) begin miscompares++; $display("FAIL halt_cyc got cyc=%0d done=%0b want 2/0", aCycle, aDone); end
    aValid = 0; aHalt = 0;
    @(negedge clk);
    vectors++; if (aDone !== 1'b1 || aTValid !== 1'b0) begin miscompares++; $display("FAIL halt_done got done=%0b v=%0b want 1/0", aDone, aTValid); end
    aValid = 1; aRegwrite = 1; aWdata = 16'h0BAD;
    @(negedge clk);
    vectors++; if (aTValid !== 1'b0) begin miscompares++; $display("FAIL after_done got v=%0b want 0", aTValid); end
    aValid = 0; aRegwrite = 0;
  endtask

  task automatic test_ld_st();
    doReset();
    aValid = 1; aRegwrite = 1; aMemread = 1; aWreg = 4'd5; aWdata = 16'h1234; aAddr = 16'h0010; aPc = 16'h0008;
    @(negedge clk);
    vectors++; if (aKind !== 3'd2 || aReg !== 4'd5) begin miscompares++; $display("FAIL ld_kind got kind=%0d r=%0d want 2/5", aKind, aReg); end
    vectors++; if (aValue !== 16'h1234 || aTAddr !== 16'h0010) begin miscompares++; $display("FAIL ld_fields got v=%h a=%h want 1234/0010", aValue, aTAddr); end
    aRegwrite = 0; aMemread = 0; aMemwrite = 1; aWreg = 4'd7; aWdata = 16'h9999; aAddr = 16'h0020; aMdata = 16'h5555; aPc = 16'h000A;
    @(negedge clk);
    vectors++; if (aKind !== 3'd2 || aValue !== 16'h1234) begin miscompares++; $display("FAIL ld_stable got kind=%0d v=%h want 2/1234", aKind, aValue); end
    aMemwrite = 0; aPc = 16'h000C; aAddr = 16'h0030; aWdata = 16'h7777; aMdata = 16'h6666; aReady = 1;
    @(negedge clk);
    vectors++; if (aKind !== 3'd3 || aInum !== 32'd1) begin miscompares++; $display("FAIL st_kind got kind=%0d inum=%0d want 3/1", aKind, aInum); end
    vectors++; if (aValue !== 16'h5555 || aTAddr !== 16'h0020 || aReg !== 4'd0) begin miscompares++; $display("FAIL st_fields got v=%h a=%h r=%0d want 5555/0020/0", aValue, aTAddr, aReg); end
    aValid = 0;
    @(negedge clk);
    vectors++; if (aKind !== 3'd0 || aInum !== 32'd2 || aTValid !== 1'b1) begin miscompares++; $display("FAIL nop_kind got kind=%0d inum=%0d v=%0b want 0/2/1", aKind, aInum, aTValid); end
    vectors++; if (aValue !== 16'h0 || aTAddr !== 16'h0 || aTPc !== 16'h000C) begin miscompares++; $display("FAIL nop_fields got v=%h a=%h pc=%h want 0/0/000c", aValue, aTAddr, aTPc); end
    aReady = 0;
  endtask

  task automatic test_overflow();
    logic [31:0] expInum [3];
    expInum[0] = 32'd2; expInum[1] = 32'd3; expInum[2] = 32'd6;
    doReset();
    bValid = 2'b11; bRegwrite = 2'b11; bWreg = {4'd2, 4'd1}; bWdata = {16'h0002, 16'h0001}; bPc = {16'h0012, 16'h0010};
    @(negedge clk);
    vectors++; if (bInum !== 32'd0 || bOverflow !== 1'b0) begin miscompares++; $display("FAIL ovf_c1 got inum=%0d ov=%0b want 0/0", bInum, bOverflow); end
    @(negedge clk);
    vectors++; if (bOverflow !== 1'b0 || bDrop !== 32'd0) begin miscompares++; $display("FAIL ovf_full got ov=%0b drop=%0d want 0/0", bOverflow, bDrop); end
    @(negedge clk);
    vectors++; if (bOverflow !== 1'b1 || bDrop !== 32'd2) begin miscompares++; $display("FAIL ovf_drop got ov=%0b drop=%0d want 1/2", bOverflow, bDrop); end
    vectors++; if (bInum !== 32'd0 || bTValid !== 1'b1) begin miscompares++; $display("FAIL ovf_head got inum=%0d v=%0b want 0/1", bInum, bTValid); end
    bValid = 2'b00; bReady = 1;
    @(negedge clk);
    vectors++; if (bInum !== 32'd1) begin miscompares++; $display("FAIL ovf_pop got inum=%0d want 1", bInum); end
    bReady = 0; bValid = 2'b11; bWdata = {16'h0070, 16'h0060}; bPc = {16'h0072, 16'h0070};
    @(negedge clk);
    vectors++; if (bDrop !== 32'd3) begin miscompares++; $display("FAIL ovf_partial got drop=%0d want 3", bDrop); end
    bValid = 2'b00; bReady = 1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      vectors++; if (bInum !== expInum[n]) begin miscompares++; $display("FAIL ovf_drain%0d got inum=%0d want %0d", n, bInum, expInum[n]); end
    end
    vectors++; if (bValue !== 16'h0060 || bCycle !== 32'd5) begin miscompares++; $display("FAIL ovf_slot0 got v=%h cyc=%0d want 0060/5", bValue, bCycle); end
    @(negedge clk);
    vectors++; if (bTValid !== 1'b0) begin miscompares++; $display("FAIL ovf_empty got v=%0b want 0", bTValid); end
    bReady = 0;
  endtask

  task automatic test_halt_dual();
    doReset();
    bValid = 2'b11; bHalt = 2'b01; bRegwrite = 2'b10; bWdata = {16'h00EE, 16'h0000}; bPc = {16'h0042, 16'h0040};
    @(negedge clk);
    vectors++; if (bKind !== 3'd4 || bInum !== 32'd0 || bTPc !== 16'h0040) begin miscompares++; $display("FAIL hd_rec got kind=%0d inum=%0d pc=%h want 4/0/0040", bKind, bInum, bTPc); end
    vectors++; if (bDone !== 1'b0 || bTValid !== 1'b1) begin miscompares++; $display("FAIL hd_halted got done=%0b v=%0b want 0/1", bDone, bTValid); end
    bHalt = 2'b00; bRegwrite = 2'b01; bValid = 2'b01; bReady = 1;
    @(negedge clk);
    vectors++; if (bTValid !== 1'b0 || bDone !== 1'b1 || bDrop !== 32'd0) begin miscompares++; $display("FAIL hd_done got v=%0b done=%0b drop=%0d want 0/1/0", bTValid, bDone, bDrop); end
    bValid = 0; bRegwrite = 0; bReady = 0;
  endtask

  task automatic test_timeout();
    doReset();
    bValid = 2'b01; bPc = {16'h0000, 16'h0100};
    @(negedge clk);
    bValid = 2'b00;
    repeat (49) @(negedge clk);
    vectors++; if (bTimeout !== 1'b0 || bDone !== 1'b0) begin miscompares++; $display("FAIL wd_early got to=%0b done=%0b want 0/0", bTimeout, bDone); end
    @(negedge clk);
    vectors++; if (bTimeout !== 1'b1 || bDone !== 1'b1) begin miscompares++; $display("FAIL wd_fire got to=%0b done=%0b want 1/1", bTimeout, bDone); end
    vectors++; if (bTValid !== 1'b1 || bTPc !== 16'h0100) begin miscompares++; $display("FAIL wd_nodrain got v=%0b pc=%h want 1/0100", bTValid, bTPc); end
  endtask

  task automatic test_reset_mid();
    doReset();
    aValid = 1; aRegwrite = 1; aWreg = 4'd1; aWdata = 16'h0101;
    repeat (3) @(negedge clk);
    vectors++; if (aTValid !== 1'b1 || aInum !== 32'd0) begin miscompares++; $display("FAIL rm_queued got v=%0b inum=%0d want 1/0", aTValid, aInum); end
    aValid = 0; aReady = 1;
    rst_n = 0;
    #1;
    vectors++; if (aTValid !== 1'b0 || aKind !== 3'd0 || aDrop !== 32'd0 || aDone !== 1'b0) begin miscompares++; $display("FAIL rm_async got v=%0b kind=%0d drop=%0d done=%0b want 0", aTValid, aKind, aDrop, aDone); end
    @(negedge clk);
    rst_n = 1; aReady = 0;
    aValid = 1; aRegwrite = 1; aWreg = 4'd2; aWdata = 16'h0BEE;
    @(negedge clk);
    vectors++; if (aInum !== 32'd0 || aCycle !== 32'd1 || aValue !== 16'h0BEE) begin miscompares++; $display("FAIL rm_restart got inum=%0d cyc=%0d v=%h want 0/1/0bee", aInum, aCycle, aValue); end
    aValid = 0; aRegwrite = 0;
  endtask

  initial begin
    clearInputs();
    test_reset();
    test_reg_halt();
    test_ld_st();
    test_overflow();
    test_halt_dual();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL sim_timeout got no finish want finish before 100000");
    $fatal(1);
  end

endmodule

// File: doc/retire_trace_buffer.md
# retire_trace_buffer

Synthesizable retire-trace capture unit for the pipelined CPU generation; successor to the phase-1 bench-side trace logic. It classifies up to `NUM_PORTS` retiring instructions per cycle into REG/LD/ST/NOP/HALT records tagged with instruction number and cycle stamp, and buffers them in a FIFO. Records are drained over a valid/ready port for the trace writer or a debug UART. It also provides the halt-drain sequence and the cycle watchdog in hardware.

## Interface
- `NUM_PORTS`, 1: retire slots per cycle (1 or 2); slot 0 is oldest.
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2·NUM_PORTS.
- `CYC_W`, 32: width of cycle and instruction counters.
- `MAX_CYCLES`, 100000: watchdog limit.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ret_valid` in NUM_PORTS: slot retires this cycle.
- `ret_pc` in 16·NUM_PORTS: PC per slot.
- `ret_regwrite`, `ret_memread`, `ret_memwrite`, `ret_halt` in NUM_PORTS each: per-slot flags.
- `ret_wreg` in 4·NUM_PORTS: destination register.
- `ret_wdata` in 16·NUM_PORTS: register write data.
- `ret_addr` in 16·NUM_PORTS: memory address.
- `ret_mdata` in 16·NUM_PORTS: store data.
- `trace_valid` out 1: head record available.
- `trace_ready` in 1: consumer accepts head.
- `trace_kind` out 3: 0 NOP, 1 REG, 2 LD, 3 ST, 4 HALT.
- `trace_inum`, `trace_cycle` out CYC_W each: instruction number and cycle stamp.
- `trace_pc`, `trace_value`, `trace_addr` out 16 each; `trace_reg` out 4.
- `overflow` out 1: sticky, ≥1 record dropped.
- `drop_count` out CYC_W: dropped records.
- `timeout` out 1: sticky, watchdog expired.
- `done` out 1: halt recorded and FIFO fully drained.

## Operation
- Reset values: all outputs 0; FIFO empty; counters 0; state RUN.
- `cycle` increments every clock while `rst_n`=1; it is 1 on the first post-reset edge.
- Classification per valid slot, first match wins:
  - `halt` → HALT.
  - `regwrite&memread` → LD, with reg, value=wdata, addr.
  - `regwrite` → REG.
  - `memwrite` → ST, with addr, value=mdata.
  - otherwise NOP.
- Unused record fields are 0.
- `inum` is the value of the instruction counter before increment. Slots are numbered in port order; the counter advances by the popcount of `ret_valid`, including dropped records.
- Push at most NUM_PORTS records per cycle.
- Free space is computed from occupancy at the start of the cycle; a same-cycle pop does not create room.
- When the records do not fit, the youngest slots are dropped: `overflow` is set and `drop_count` is incremented by the number dropped.
- States:
  - RUN: accepts retires.
  - HALTED: entered on the cycle a HALT record is accepted or dropped. Older same-cycle slots are kept; younger slots and all later retires are ignored and not counted.
  - DONE: entered from HALTED when the FIFO is empty; `done`=1. Exit only by reset.
- Watchdog: when `cycle` > MAX_CYCLES in RUN, `timeout` is set and the state goes to DONE without draining.
- Pop: happens when `trace_valid & trace_ready`. Head fields are stable while `trace_valid`=1 and not popped.
- Counter wrap: counters saturate at all-ones; no wrap.

## Timing
- A retire presented before edge k is visible on `trace_*` after edge k, when the FIFO was empty (1-cycle latency).
- One pop per cycle. Push and pop in the same cycle are legal; occupancy changes by pushes−1.
- `done` asserts the cycle after the final pop.
- Reset mid-operation clears the FIFO, sticky flags and state immediately (asynchronous).

## Structure
- Package `trace_pkg`:
  - `trace_kind_e` enum.
  - `trace_rec_t` struct: kind, inum, cycle, pc, reg, value, addr.
  - State enum.
- Sub-module `trace_fifo`: multi-push (NUM_PORTS), single-pop circular buffer storing `trace_rec_t`, with pointer wrap modulo DEPTH and an occupancy counter of width log2(DEPTH)+1.
- Top level: classifier, counters, FSM, watchdog.

## Test plan
- NUM_PORTS=1; retire REG r3=0x00AB at PC 0x0002, then HALT at PC 0x0004; `trace_ready`=1 → records (REG, inum 0, r3, 0x00AB) and (HALT, inum 1, pc 0x0004); `done` asserts the cycle after the second pop.
- Retire with memread+regwrite, addr 0x0010, data 0x1234 → LD record with reg, value 0x1234, addr 0x0010. Memwrite with mdata 0x5555 → ST record with value 0x5555.
- NUM_PORTS=2, DEPTH=4, `trace_ready`=0; three dual-slot cycles → 4 records held; 2 dropped from slot 0 and slot 1 of cycle 3; `overflow`=1, `drop_count`=2; next inum=6.
- Dual slot: slot0 HALT, slot1 REG → only HALT recorded; slot1 not counted; state HALTED.
- MAX_CYCLES=50, no halt → `timeout`=1 and `done`=1 at cycle 51.
- Assert `rst_n`=0 mid-drain with 3 entries queued → `trace_valid`=0 immediately and counters 0; after release, the first record is stamped inum 0, cycle ≥ 1.
